// File: rtl/uart_cmd_parser.sv
// -----------------------------------------------------------------------------
// uart_cmd_parser
// Finds framed commands in a UART byte stream. A frame is the three header
// bytes HDR0 HDR1 HDR2 followed by two payload bytes (command id, argument).
// A completed frame updates o_cmd_id/o_cmd_arg and pulses o_cmd_valid for one
// cycle. Header mismatches and inter-byte timeouts abort the frame and bump a
// saturating error counter.
//
// Ports
//   i_clk        system clock, rising edge
//   i_rst        asynchronous active-high reset
//   i_rx_data    received byte
//   i_rx_valid   one-cycle strobe qualifying i_rx_data
//   o_cmd_valid  one-cycle pulse, o_cmd_id/o_cmd_arg hold a new command
//   o_cmd_id     first payload byte of the last completed frame
//   o_cmd_arg    second payload byte of the last completed frame
//   o_err_cnt    saturating count of aborted frames
//   o_busy       high whenever the FSM is not in IDLE
//   o_state      current FSM state (debug visibility)
//
// Handshake: i_rx_valid is a strobe with no back-pressure; every cycle with
// i_rx_valid=1 consumes exactly one byte, including consecutive cycles.
// -----------------------------------------------------------------------------
module uart_cmd_parser #(
   parameter int unsigned TIMEOUT_CYC = 4096,
   parameter logic [7:0]  HDR0        = 8'h63,
   parameter logic [7:0]  HDR1        = 8'h6D,
   parameter logic [7:0]  HDR2        = 8'h64
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic [7:0] i_rx_data,
   input  logic       i_rx_valid,
   output logic       o_cmd_valid,
   output logic [7:0] o_cmd_id,
   output logic [7:0] o_cmd_arg,
   output logic [7:0] o_err_cnt,
   output logic       o_busy,
   output logic [2:0] o_state
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_H1   = 3'd1;
   localparam logic [2:0] S_H2   = 3'd2;
   localparam logic [2:0] S_P0   = 3'd3;
   localparam logic [2:0] S_P1   = 3'd4;

   // Last idle count still tolerated; one more silent cycle aborts the frame.
   localparam logic [15:0] GAP_LAST = 16'(TIMEOUT_CYC - 1);

   logic [2:0]  r_state;
   logic [15:0] r_gap;
   logic [7:0]  r_id;
   logic        r_cmd_valid;
   logic [7:0]  r_cmd_id;
   logic [7:0]  r_cmd_arg;
   logic [7:0]  r_err_cnt;

   logic [2:0]  w_state_nxt;
   logic        w_err;
   logic        w_done;
   logic        w_timeout;

   always_comb begin
      w_state_nxt = r_state;
      w_err       = 1'b0;
      w_done      = 1'b0;
      // A byte in the same cycle as the timeout wins (checked first below).
      w_timeout   = (r_state != S_IDLE) && !i_rx_valid && (r_gap == GAP_LAST);
      if (i_rx_valid) begin
         case (r_state)
            S_IDLE: begin
               if (i_rx_data == HDR0) w_state_nxt = S_H1;
            end
            S_H1: begin
               if (i_rx_data == HDR1) begin
                  w_state_nxt = S_H2;
               end else begin
                  // Resync: a mismatching HDR0 may start the next frame.
                  w_err       = 1'b1;
                  w_state_nxt = (i_rx_data == HDR0) ? S_H1 : S_IDLE;
               end
            end
            S_H2: begin
               if (i_rx_data == HDR2) begin
                  w_state_nxt = S_P0;
               end else begin
                  w_err       = 1'b1;
                  w_state_nxt = (i_rx_data == HDR0) ? S_H1 : S_IDLE;
               end
            end
            // Payload bytes are opaque, HDR0 included.
            S_P0:    w_state_nxt = S_P1;
            S_P1: begin
               w_state_nxt = S_IDLE;
               w_done      = 1'b1;
            end
            default: w_state_nxt = S_IDLE;
         endcase
      end else if (w_timeout) begin
         w_state_nxt = S_IDLE;
         w_err       = 1'b1;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state     <= S_IDLE;
         r_gap       <= 16'd0;
         r_id        <= 8'd0;
         r_cmd_valid <= 1'b0;
         r_cmd_id    <= 8'd0;
         r_cmd_arg   <= 8'd0;
         r_err_cnt   <= 8'd0;
      end else begin
         r_state     <= w_state_nxt;
         r_cmd_valid <= w_done;
         if (i_rx_valid && (r_state == S_P0)) r_id <= i_rx_data;
         // Outputs only change on a completed frame.
         if (w_done) begin
            r_cmd_id  <= r_id;
            r_cmd_arg <= i_rx_data;
         end
         if (w_err && (r_err_cnt != 8'hFF)) r_err_cnt <= r_err_cnt + 8'd1;
         // Stays at zero in IDLE, counts silent cycles inside a frame.
         if (i_rx_valid || (w_state_nxt == S_IDLE)) r_gap <= 16'd0;
         else                                      r_gap <= r_gap + 16'd1;
      end
   end

   assign o_cmd_valid = r_cmd_valid;
   assign o_cmd_id    = r_cmd_id;
   assign o_cmd_arg   = r_cmd_arg;
   assign o_err_cnt   = r_err_cnt;
   assign o_busy      = (r_state != S_IDLE);
   assign o_state     = r_state;

endmodule

// File: tb/tb_uart_cmd_parser.sv
module tb_uart_cmd_parser;

  logic       clk;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       cmd_valid;
  logic [7:0] cmd_id;
  logic [7:0] cmd_arg;
  logic [7:0] err_cnt;
  logic       busy;
  logic [2:0] state;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [15:0] exp_q[$];
  int          exp_cyc_q[$];

  uart_cmd_parser dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_rx_data   (rx_data),
    .i_rx_valid  (rx_valid),
    .o_cmd_valid (cmd_valid),
    .o_cmd_id    (cmd_id),
    .o_cmd_arg   (cmd_arg),
    .o_err_cnt   (err_cnt),
    .o_busy      (busy),
    .o_state     (state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks (called at a negedge, return at a negedge) ----------------
  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  // Last byte of a frame: the command is expected right after the consuming edge.
  task automatic send_last(input logic [7:0] b, input logic [7:0] id, input logic [7:0] arg);
    exp_q.push_back({id, arg});
    exp_cyc_q.push_back(cyc + 1);
    send_byte(b);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(2);
    check("rst_cmd_valid", {15'd0, cmd_valid}, 16'd0);
    check("rst_cmd_id",    {8'd0, cmd_id},     16'd0);
    check("rst_cmd_arg",   {8'd0, cmd_arg},    16'd0);
    check("rst_err_cnt",   {8'd0, err_cnt},    16'd0);
    check("rst_busy",      {15'd0, busy},      16'd0);
    rst = 1'b0;
    idle(1);
  endtask

  task automatic drain(input string name);
    idle(3);
    check(name, 16'(exp_q.size()), 16'd0);
    exp_q.delete();
    exp_cyc_q.delete();
  endtask

  // ---------------- stimulus + scoreboard monitor ----------------
  initial begin
    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;

    fork
      forever begin
        @(negedge clk);
        if (cmd_valid === 1'b1) begin
          n_tests++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL cmd_unexpected: actual id=%h arg=%h at cycle %0d, required no command",
                     cmd_id, cmd_arg, cyc);
          end else begin
            logic [15:0] e;
            int          ec;
            e  = exp_q.pop_front();
            ec = exp_cyc_q.pop_front();
            if ({cmd_id, cmd_arg} !== e || cyc != ec) begin
              n_fail++;
              $display("FAIL cmd: actual id/arg=%h cycle=%0d, required id/arg=%h cycle=%0d",
                       {cmd_id, cmd_arg}, cyc, e, ec);
            end
          end
        end
      end
    join_none

    idle(1);
    do_reset();

    // Spaced frame (746-cycle pitch), preceded by a stray non-header byte.
    send_byte(8'h55); idle(3);
    check("idle_junk_err", {8'd0, err_cnt}, 16'd0);
    check("idle_junk_busy", {15'd0, busy}, 16'd0);
    send_byte(8'h63); idle(745);
    check("spaced_busy", {15'd0, busy}, 16'd1);
    send_byte(8'h6D); idle(745);
    send_byte(8'h64); idle(745);
    send_byte(8'h01); idle(745);
    send_last(8'h01, 8'h01, 8'h01);
    drain("spaced_missing");
    check("spaced_err", {8'd0, err_cnt}, 16'd0);
    check("spaced_id",  {cmd_id, cmd_arg}, 16'h0101);

    // Header mismatch with resync on HDR0.
    do_reset();
    send_byte(8'h63); send_byte(8'h6D); send_byte(8'h63); send_byte(8'h6D);
    send_byte(8'h64); send_byte(8'h02);
    send_last(8'h7F, 8'h02, 8'h7F);
    drain("resync_missing");
    check("resync_err", {8'd0, err_cnt}, 16'd1);

    // Timeout boundary: bytes arriving exactly at the last tolerated cycle.
    do_reset();
    send_byte(8'h63); send_byte(8'h6D); send_byte(8'h64);
    idle(4095);
    send_byte(8'h07);
    idle(4095);
    send_last(8'h08, 8'h07, 8'h08);
    drain("edge_missing");
    check("edge_err", {8'd0, err_cnt}, 16'd0);

    // Real timeout; previous command must survive the aborted frame.
    send_byte(8'h63); send_byte(8'h6D); send_byte(8'h64); send_byte(8'h05);
    idle(4095);
    check("pre_timeout_busy", {15'd0, busy}, 16'd1);
    idle(1);
    check("timeout_busy", {15'd0, busy}, 16'd0);
    check("timeout_err",  {8'd0, err_cnt}, 16'd1);
    send_byte(8'h09); idle(2);
    check("after_timeout_busy", {15'd0, busy}, 16'd0);
    drain("timeout_extra");
    check("timeout_hold", {cmd_id, cmd_arg}, 16'h0708);

    // HDR0 values as payload, back to back.
    do_reset();
    send_byte(8'h63); send_byte(8'h6D); send_byte(8'h64); send_byte(8'h63);
    send_last(8'h63, 8'h63, 8'h63);
    drain("hdr_payload_missing");
    check("hdr_payload_err", {8'd0, err_cnt}, 16'd0);

    // Error counter saturation.
    do_reset();
    for (int i = 0; i < 260; i++) begin
      send_byte(8'h63); send_byte(8'h00);
      if (i == 9) check("err_count_10", {8'd0, err_cnt}, 16'd10);
    end
    check("err_sat", {8'd0, err_cnt}, 16'h00FF);
    send_byte(8'h63); send_byte(8'h00);
    check("err_sat_hold", {8'd0, err_cnt}, 16'h00FF);
    send_byte(8'h63); send_byte(8'h6D); send_byte(8'h64); send_byte(8'hAA);
    send_last(8'h55, 8'hAA, 8'h55);
    drain("sat_missing");
    check("sat_err_final", {8'd0, err_cnt}, 16'h00FF);

    // Reset mid-frame, then a clean frame.
    send_byte(8'h63); send_byte(8'h6D); send_byte(8'h64); send_byte(8'h10);
    check("midframe_busy", {15'd0, busy}, 16'd1);
    do_reset();
    check("post_rst_busy", {15'd0, busy}, 16'd0);
    check("post_rst_err",  {8'd0, err_cnt}, 16'd0);
    send_byte(8'h63); send_byte(8'h6D); send_byte(8'h64); send_byte(8'h11);
    send_last(8'h22, 8'h11, 8'h22);
    drain("post_rst_missing");
    check("post_rst_cmd", {cmd_id, cmd_arg}, 16'h1122);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_cmd_parser.md
UART_CMD_PARSER -- requirements
Module: uart_cmd_parser

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 4096, giving the maximum idle clock cycles allowed between bytes inside a frame (range 2..65535).
REQ-002 SHALL have parameter HDR0/HDR1/HDR2, default 8'h63/8'h6D/8'h64 ("cmd"), giving the header byte values.
REQ-003 Clk  input  1  system clock; all logic rising-edge.
REQ-004 Rst  input  1  reset, asynchronous, active-high.
REQ-005 RxData  input  8  received byte from the UART receive path.
REQ-006 RxValid  input  1  one-cycle strobe; RxData is valid this cycle.
REQ-007 CmdValid  output  1  one-cycle pulse; CmdId/CmdArg hold a new command.
REQ-008 CmdId  output  8  command identifier (first payload byte).
REQ-009 CmdArg  output  8  command argument (second payload byte).
REQ-010 ErrCnt  output  8  saturating count of aborted frames.
REQ-011 Busy  output  1  high while the FSM is in any state other than IDLE.

Function
REQ-012 FSM states SHALL be IDLE, H1 (HDR0 seen), H2 (HDR0,HDR1 seen), P0 (header complete), P1 (CmdId captured).
REQ-013 Bytes SHALL be consumed only in cycles with RxValid=1; RxData is ignored otherwise.
REQ-014 IDLE: byte==HDR0 -> H1; any other byte -> IDLE, no error.
REQ-015 H1: byte==HDR1 -> H2; H2: byte==HDR2 -> P0.
REQ-016 Header mismatch in H1/H2 SHALL increment ErrCnt and go to H1 if byte==HDR0, else IDLE (resync).
REQ-017 P0: any byte SHALL be latched into an internal id register -> P1.
REQ-018 P1: any byte SHALL be latched as arg; next state IDLE.
REQ-019 CmdValid SHALL assert exactly in the cycle after the RxValid that completed P1, for exactly one cycle.
REQ-020 CmdId and CmdArg SHALL update in the same cycle CmdValid asserts and hold until the next completed frame.
REQ-021 Partial frames SHALL never alter CmdId/CmdArg.
REQ-022 Gap counter (16 bit) SHALL clear on every accepted byte and on entry to IDLE, and increment each cycle in H1/H2/P0/P1 without RxValid.
REQ-023 When the gap counter reaches TIMEOUT_CYC-1 with no RxValid, FSM SHALL go to IDLE next cycle and ErrCnt SHALL increment.
REQ-024 If RxValid arrives in the same cycle as the timeout condition, the byte SHALL be processed normally and no timeout SHALL occur.
REQ-025 In IDLE the gap counter SHALL stay at 0; no timeout in IDLE.
REQ-026 ErrCnt SHALL saturate at 8'hFF and never wrap.
REQ-027 A byte equal to HDR0 received in P0 or P1 SHALL be treated as payload, not a resync.
REQ-028 Back-to-back RxValid on consecutive cycles SHALL be accepted with no byte loss.
REQ-029 Busy SHALL be combinational from state (IDLE -> 0).

Reset
REQ-030 While Rst=1: state IDLE, CmdValid=0, CmdId=0, CmdArg=0, ErrCnt=0, Busy=0, gap counter 0.
REQ-031 Rst asserted mid-frame SHALL discard the partial frame immediately without incrementing ErrCnt and without pulsing CmdValid.
REQ-032 After Rst release the first accepted byte SHALL be evaluated in IDLE.

Verification
REQ-033 Bytes 63 6D 64 01 01 spaced 746 cycles -> one CmdValid pulse, CmdId=01, CmdArg=01, ErrCnt=0, cycle after last RxValid.
REQ-034 Bytes 63 6D 63 6D 64 02 7F -> ErrCnt=1, one CmdValid with CmdId=02, CmdArg=7F.
REQ-035 Bytes 63 6D 64 05 then 4096 idle cycles, then 09 -> ErrCnt=1, Busy=0 after timeout, no CmdValid; 09 ignored.
REQ-036 Bytes 63 6D 64 63 63 on consecutive cycles -> CmdValid with CmdId=63, CmdArg=63.
REQ-037 260 frames of 63 00 (mismatch) -> ErrCnt=FF and holds; then 63 6D 64 AA 55 -> CmdId=AA, CmdArg=55.
REQ-038 Rst pulsed after 63 6D 64 10 -> no CmdValid, ErrCnt=0, Busy=0; following full frame 63 6D 64 11 22 decodes CmdId=11, CmdArg=22.
